// File: rtl/uart_image_tx.sv
// Streams a NUM_BYTES*8-bit image as back-to-back 8N1 UART frames, byte 0 first, LSB first.
// Optional macro UART_TX_STOP2_EN: two stop bits per frame (11-bit frames).
module uart_image_tx #(
  parameter int unsigned BAUD_DIV  = 2603,
  parameter int unsigned NUM_BYTES = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [NUM_BYTES*8-1:0] Image,
  output logic                   TX,
  output logic                   Busy,
  output logic                   Done,
  output logic [4:0]             Byte_idx
);

  localparam logic [12:0] BaudMax = 13'(BAUD_DIV);
  localparam logic [4:0]  LastIdx = 5'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 state_q, state_d;
  logic [12:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [NUM_BYTES*8-1:0] sh_q, sh_d;
  logic [4:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end;
  logic                   stop_end;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bit_end = (cnt_q == BaudMax);

`ifdef UART_TX_STOP2_EN
  // Second stop period is tracked with the (otherwise idle) bit counter.
  assign stop_end = bit_end && (bit_q == 3'd1);
`else
  assign stop_end = bit_end;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 13'd1;
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (Start) begin
          state_d = StStart;
          sh_d    = Image;
          idx_d   = '0;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          // Shift after every bit so the next byte's LSB lands in sh_q[0].
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          tx_d  = sh_q[1];
          if (bit_q == 3'd7) begin
            state_d = StStop;
            bit_d   = '0;
            tx_d    = 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_end && !stop_end) begin
          bit_d = bit_q + 3'd1;
        end else if (stop_end) begin
          bit_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = StStart;
            idx_d   = idx_q + 5'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign TX       = tx_q;
  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign Byte_idx = idx_q;

endmodule

// File: tb/tb_uart_image_tx.sv
// Scoreboard bench for uart_image_tx: stimulus queues per-cycle expected line state,
// a negedge monitor pops and compares whenever the DUT is Busy or pulses Done.
module tb_uart_image_tx;

  localparam int D  = 3;
  localparam int NB = 2;
`ifdef UART_TX_STOP2_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int FB = 9 + STOPS;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] idx;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [NB*8-1:0] Image;
  logic          TX;
  logic          Busy;
  logic          Done;
  logic [4:0]    Byte_idx;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  uart_image_tx #(
    .BAUD_DIV (D),
    .NUM_BYTES(NB)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Image   (Image),
    .TX      (TX),
    .Busy    (Busy),
    .Done    (Done),
    .Byte_idx(Byte_idx)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected line state for every clock of one image, then the Done cycle.
  task automatic push_image(input logic [NB*8-1:0] img);
    logic b;
    for (int by = 0; by < NB; by++) begin
      for (int k = 0; k < FB; k++) begin
        if (k == 0) b = 1'b0;
        else if (k <= 8) b = img[by*8 + k - 1];
        else b = 1'b1;
        repeat (D + 1) q.push_back('{tx: b, busy: 1'b1, done: 1'b0, idx: 5'(by)});
      end
    end
    q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1, idx: 5'(NB - 1)});
  endtask

  always @(negedge Clk) begin
    if (mon_en && !Reset && (Busy || Done)) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'({Busy, Done}), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("tx", 32'(TX), 32'(e.tx));
        check("busy", 32'(Busy), 32'(e.busy));
        check("done", 32'(Done), 32'(e.done));
        check("byte_idx", 32'(Byte_idx), 32'(e.idx));
      end
    end
  end

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (q.size() == 0) break;
    end
    check("drain_remaining", 32'(q.size()), 32'd0);
  endtask

  task automatic idle_check(input logic [4:0] idx);
    repeat (4) @(negedge Clk);
    check("idle_tx", 32'(TX), 32'd1);
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_done", 32'(Done), 32'd0);
    check("idle_byte_idx", 32'(Byte_idx), 32'(idx));
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Image = '0;
    repeat (3) @(negedge Clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_byte_idx", 32'(Byte_idx), 32'd0);
    Reset = 1'b0;
    mon_en = 1'b1;
    repeat (6) @(negedge Clk);
    idle_check(5'd0);

    // Basic image; Image changed right after acceptance must not matter.
    Image = 16'hA55A;
    push_image(16'hA55A);
    pulse_start();
    Image = 16'hFFFF;
    wait_drain(400);
    idle_check(5'(NB - 1));

    // Start pulse during byte 1 with a different image is ignored.
    Image = 16'h3C81;
    push_image(16'h3C81);
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (Byte_idx == 5'd1) break;
    end
    check("reached_byte1", 32'(Byte_idx), 32'd1);
    Image = 16'h0000;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_drain(400);
    idle_check(5'(NB - 1));

    // Start held: a second image starts in the cycle after Done.
    Image = 16'h00FF;
    push_image(16'h00FF);
    push_image(16'h00FF);
    @(negedge Clk);
    Start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (q.size() < NB * FB * (D + 1)) break;
    end
    Start = 1'b0;
    wait_drain(400);
    idle_check(5'(NB - 1));

    // Asynchronous reset in the middle of byte 0's data bits.
    Image = 16'h0000;
    push_image(16'h0000);
    pulse_start();
    repeat (6) @(negedge Clk);
    check("pre_reset_tx_low", 32'(TX), 32'd0);
    mon_en = 1'b0;
    #1 Reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(TX), 32'd1);
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_done", 32'(Done), 32'd0);
    check("async_rst_byte_idx", 32'(Byte_idx), 32'd0);
    q.delete();
    repeat (3) begin
      @(negedge Clk);
      check("rst_hold_done", 32'(Done), 32'd0);
    end
    Reset = 1'b0;
    mon_en = 1'b1;
    idle_check(5'd0);

    // Restart after reset begins again at byte 0.
    Image = 16'h1234;
    push_image(16'h1234);
    pulse_start();
    wait_drain(400);
    idle_check(5'(NB - 1));

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
